// File: rtl/rtc_set_ctrl_if.sv
// Button, time and load/tick bundle between the time-set controller and the
// HH:MM:SS counter datapath. The master drives buttons and the current time.
interface rtc_set_ctrl_if;
   logic        MODE_BTN;
   logic        INC_BTN;
   logic [3:0]  HRM;
   logic [3:0]  HRL;
   logic [3:0]  MIN_M;
   logic [3:0]  MIN_L;
   logic [3:0]  SEC_M;
   logic [3:0]  SEC_L;
   logic        TICK;
   logic        LOAD;
   logic [23:0] LD_TIME;
   logic        EDIT;
   logic [1:0]  FIELD;

   modport master (
      output MODE_BTN, INC_BTN, HRM, HRL, MIN_M, MIN_L, SEC_M, SEC_L,
      input  TICK, LOAD, LD_TIME, EDIT, FIELD
   );

   modport slave (
      input  MODE_BTN, INC_BTN, HRM, HRL, MIN_M, MIN_L, SEC_M, SEC_L,
      output TICK, LOAD, LD_TIME, EDIT, FIELD
   );
endinterface

// File: rtl/rtc_set_ctrl.sv
// Time-set and tick controller: one-second prescaler for the BCD counter plus
// a MODE/INC edit sequence on a shadow copy that is written back with LOAD.
module rtc_set_ctrl #(
   parameter int TICK_DIV    = 4,
   parameter int REPEAT_DLY  = 8,
   parameter int REPEAT_RATE = 4
) (
   input  logic          CLK,
   input  logic          RST_N,
   rtc_set_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2,
      SET_SEC = 2'd3
   } state_t;

   localparam int PRE_W   = $clog2(TICK_DIV);
   localparam int RPT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   state_t             state;
   logic [PRE_W-1:0]   pre;
   logic [23:0]        shadow;
   logic [23:0]        cur_time;
   logic [RPT_W-1:0]   rpt_cnt;
   logic               rpt_on;
   logic               mode_q;
   logic               inc_q;
   logic               mode_ev;
   logic               inc_ev;
   logic               inc_rise;
   logic               inc_held;
   logic               rpt_fire;
   logic               in_set;
   logic               tick_r;
   logic               load_r;
   logic [23:0]        ld_time_r;
   logic               edit_r;
   logic [1:0]         field_r;

   // Two-digit BCD increment with wrap to 00 once the field limit is reached.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
      logic [7:0] r;
      if (v >= lim)
         r = 8'h00;
      else if (v[3:0] >= 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   assign cur_time = {bus.HRM, bus.HRL, bus.MIN_M, bus.MIN_L, bus.SEC_M, bus.SEC_L};
   assign in_set   = (state != RUN);
   assign inc_rise = bus.INC_BTN & ~inc_q;
   // rpt_cnt==0 marks an idle repeat engine, so a hold carried over a MODE
   // change never resumes repeating in the new field.
   assign inc_held = bus.INC_BTN & inc_q & (rpt_cnt != '0);
   assign rpt_fire = rpt_on ? (rpt_cnt == RPT_W'(REPEAT_RATE))
                            : (rpt_cnt == RPT_W'(REPEAT_DLY));

   // Button edge registers: events act one cycle after the sampled edge.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mode_q  <= 1'b0;
         inc_q   <= 1'b0;
         mode_ev <= 1'b0;
      end else begin
         mode_q  <= bus.MODE_BTN;
         inc_q   <= bus.INC_BTN;
         mode_ev <= bus.MODE_BTN & ~mode_q;
      end
   end

   // Increment event generation: immediate, delayed first repeat, then periodic.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         rpt_cnt <= '0;
         rpt_on  <= 1'b0;
         inc_ev  <= 1'b0;
      end else if (mode_ev || !in_set) begin
         rpt_cnt <= '0;
         rpt_on  <= 1'b0;
         inc_ev  <= 1'b0;
      end else if (inc_rise) begin
         rpt_cnt <= RPT_W'(1);
         rpt_on  <= 1'b0;
         inc_ev  <= 1'b1;
      end else if (inc_held) begin
         inc_ev <= rpt_fire;
         if (rpt_fire) begin
            rpt_cnt <= RPT_W'(1);
            rpt_on  <= 1'b1;
         end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
         end
      end else begin
         rpt_cnt <= '0;
         rpt_on  <= 1'b0;
         inc_ev  <= 1'b0;
      end
   end

   // Edit FSM, shadow register, load strobe and prescaler.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= RUN;
         pre       <= '0;
         shadow    <= '0;
         tick_r    <= 1'b0;
         load_r    <= 1'b0;
         ld_time_r <= '0;
         edit_r    <= 1'b0;
         field_r   <= 2'd0;
      end else begin
         load_r <= 1'b0;
         case (state)
            RUN: begin
               if (mode_ev) begin
                  state   <= SET_HR;
                  edit_r  <= 1'b1;
                  field_r <= 2'd1;
                  shadow  <= cur_time;
               end
            end
            SET_HR: begin
               if (mode_ev) begin
                  state   <= SET_MIN;
                  field_r <= 2'd2;
               end else if (inc_ev) begin
                  shadow[23:16] <= bcd_inc(shadow[23:16], 8'h23);
               end
            end
            SET_MIN: begin
               if (mode_ev) begin
                  state   <= SET_SEC;
                  field_r <= 2'd3;
               end else if (inc_ev) begin
                  shadow[15:8] <= bcd_inc(shadow[15:8], 8'h59);
               end
            end
            SET_SEC: begin
               if (mode_ev) begin
                  state     <= RUN;
                  edit_r    <= 1'b0;
                  field_r   <= 2'd0;
                  load_r    <= 1'b1;
                  ld_time_r <= shadow;
               end else if (inc_ev) begin
                  shadow[7:0] <= bcd_inc(shadow[7:0], 8'h59);
               end
            end
            default: begin
               state   <= RUN;
               edit_r  <= 1'b0;
               field_r <= 2'd0;
            end
         endcase

         // Leaving edit restarts the prescaler so the first TICK is a full period after LOAD.
         if (state == RUN && !mode_ev) begin
            if (pre == PRE_W'(TICK_DIV - 1)) begin
               pre    <= '0;
               tick_r <= 1'b1;
            end else begin
               pre    <= pre + PRE_W'(1);
               tick_r <= 1'b0;
            end
         end else begin
            pre    <= '0;
            tick_r <= 1'b0;
         end
      end
   end

   assign bus.TICK    = tick_r;
   assign bus.LOAD    = load_r;
   assign bus.LD_TIME = ld_time_r;
   assign bus.EDIT    = edit_r;
   assign bus.FIELD   = field_r;

endmodule

// File: doc/rtc_set_ctrl.md
# rtc_set_ctrl

Time-set and tick controller for the BCD real-time counter. It generates the counter's one-second advance enable from the system clock. It also runs a button-driven edit sequence (hours, minutes, seconds) on a shadow copy of the time. When the edit sequence ends, it writes the edited value back into the counter with a single load strobe. The block sits between the user button inputs and the HH:MM:SS counter datapath.

## Interface
- TICK_DIV, 4: CLK cycles per TICK pulse; must be ≥2.
- REPEAT_DLY, 8: cycles INC_BTN must stay high after its rising edge before auto-repeat starts; ≥1.
- REPEAT_RATE, 4: cycles between auto-repeat increments; ≥1.
- CLK  in  1  system clock, rising-edge.
- RST_N  in  1  asynchronous, active-low reset; one clock, all state in this domain.
- MODE_BTN  in  1  debounced, CLK-synchronous level; each rising edge advances the edit state.
- INC_BTN  in  1  debounced, CLK-synchronous level; increments the selected field.
- HRM, HRL, MIN_M, MIN_L, SEC_M, SEC_L  in  4 each  current BCD time from the counter.
- TICK  out  1  one-cycle advance enable to the counter.
- LOAD  out  1  one-cycle strobe: counter takes LD_TIME.
- LD_TIME  out  24  {HRM,HRL,MIN_M,MIN_L,SEC_M,SEC_L} BCD value to load.
- EDIT  out  1  high while in any SET state.
- FIELD  out  2  0=none, 1=hours, 2=minutes, 3=seconds (display blink select).

## Operation
- The FSM has four states: RUN, SET_HR, SET_MIN, SET_SEC.
- Each MODE rising edge (MODE_BTN=1 with registered previous value 0) moves RUN→SET_HR→SET_MIN→SET_SEC→RUN.
- RUN→SET_HR: on the same edge, SHADOW <= the six time inputs sampled at that edge.
- SET_SEC→RUN: on the same edge, LOAD <= 1, LD_TIME <= SHADOW, and the prescaler clears to 0.
- LD_TIME holds its last loaded value otherwise.
- Prescaler PRE runs only in RUN:
  - if PRE==TICK_DIV-1 then PRE<=0 and TICK<=1;
  - else PRE<=PRE+1 and TICK<=0.
- In SET states TICK=0 and PRE holds 0.
- Increment events (SET states only):
  - an INC rising edge gives one immediate increment;
  - if INC_BTN is still high REPEAT_DLY cycles after that edge, one increment follows;
  - after that, one increment every REPEAT_RATE cycles while INC_BTN stays high;
  - INC_BTN low clears the repeat counter.
- Field increment on SHADOW, BCD with wrap:
  - hours: value ≥0x23 → 0x00; else HRL ≥9 → HRM+1, HRL=0; else HRL+1.
  - minutes/seconds: value ≥0x59 → 0x00; else low digit ≥9 → high+1, low=0; else low+1.
  - Only the selected field changes.
- Simultaneous MODE edge and increment event in the same cycle: MODE wins, the increment is dropped, and the repeat counter is cleared.
- A state change clears the repeat counter; holding INC across a MODE change does not carry the repeat into the new field.
- EDIT and FIELD are registered, decoded from the next state: RUN→0/0, SET_HR→1/1, SET_MIN→1/2, SET_SEC→1/3.

## Timing
- Reset (RST_N=0, asynchronous), all outputs and state clear:
  - state=RUN, PRE=0, SHADOW=0, repeat counter=0, edge registers=0;
  - TICK=0, LOAD=0, LD_TIME=0, EDIT=0, FIELD=0.
- Reset mid-edit aborts the edit; no LOAD is issued.
- After RST_N deasserts, the first TICK is high after the TICK_DIV-th rising edge, then every TICK_DIV cycles.
- MODE latency: MODE_BTN high at edge N (low at N-1) → FIELD/EDIT/LOAD update after edge N+1. The edge register adds one cycle.
- LOAD is high for exactly one cycle, in the same cycle EDIT falls.
- The first TICK after LOAD comes TICK_DIV cycles after LOAD.
- Increment latency: SHADOW updates after edge N+1 for an INC rising edge sampled at edge N.
- Repeat increments land at N+1+REPEAT_DLY, then every REPEAT_RATE cycles after that.
- A time capture taken on a cycle where the counter advances keeps the pre-advance value. This is by design.

## Test plan
- Reset, then free-run 20 cycles with TICK_DIV=4 → TICK high on cycles 4, 8, 12, 16, 20 only; EDIT=0, LOAD=0 throughout.
- Time in = 12:34:56; apply MODE pulses 4 times with no INC → FIELD goes 1,2,3,0; LOAD pulses once with LD_TIME=0x123456; no TICK during edit.
- Capture 23:59:59; in SET_HR one INC → 00; in SET_MIN one INC → 00; in SET_SEC one INC → 00; exit → LD_TIME=0x000000. Also check 0x09 → 0x10 and 0x19 → 0x20 in hours.
- In SET_MIN, hold INC_BTN 30 cycles with REPEAT_DLY=8, REPEAT_RATE=4 → increments at relative cycles 1, 9, 13, 17, 21, 25, 29 (7 total); minutes 0x05 → 0x12.
- MODE and INC rising edges applied in the same cycle in SET_HR → state moves to SET_MIN, hours unchanged.
- Assert RST_N low while in SET_SEC with SHADOW edited → all outputs 0 immediately, state RUN, no LOAD pulse after release, and TICK resumes per the reset timing.
